// File: rtl/tetris_video_pipe.sv
// Tetris board renderer: maps pixel x/y + sync into RGB, querying the game board memory
// and overlaying the active piece and flashing clear rows, with sync delayed to match.
module tetris_video_pipe #(
    parameter int X0           = 200,
    parameter int Y0           = 0,
    parameter int BLK_LOG2     = 5,
    parameter int COLS         = 10,
    parameter int ROWS         = 20,
    parameter int MEM_LAT      = 1,
    parameter int FLASH_FRAMES = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [12:0]     x,
    input  logic [12:0]     y,
    input  logic [2:0]      hve,
    output logic [4:0]      req_bx,
    output logic [4:0]      req_by,
    output logic            req_valid,
    input  logic [3:0]      req_color,
    input  logic [2:0]      cur_shape,
    input  logic [1:0]      cur_rot,
    input  logic [4:0]      cur_x,
    input  logic [5:0]      cur_y,
    input  logic [3:0]      cur_color,
    input  logic [ROWS-1:0] clear_rows,
    output logic [23:0]     rgb,
    output logic [2:0]      hve_o
);
    localparam int LAT = MEM_LAT + 2;
    localparam logic [13:0] XS = 14'(X0);
    localparam logic [13:0] XE = 14'(X0 + (COLS << BLK_LOG2));
    localparam logic [13:0] YS = 14'(Y0);
    localparam logic [13:0] YE = 14'(Y0 + (ROWS << BLK_LOG2));
    localparam logic [12:0] BMASK = 13'((1 << BLK_LOG2) - 1);

    function automatic logic [15:0] shape_mask(input logic [2:0] s, input logic [1:0] r);
        logic [15:0] m;
        case ({s, r})
            5'b000_00: m = 16'h00F0;  5'b000_01: m = 16'h2222;
            5'b000_10: m = 16'h0F00;  5'b000_11: m = 16'h4444;
            5'b001_00, 5'b001_01, 5'b001_10, 5'b001_11: m = 16'h0660;
            5'b010_00: m = 16'h0270;  5'b010_01: m = 16'h0232;
            5'b010_10: m = 16'h0072;  5'b010_11: m = 16'h0262;
            5'b011_00, 5'b011_10: m = 16'h0360;
            5'b011_01, 5'b011_11: m = 16'h0462;
            5'b100_00, 5'b100_10: m = 16'h0630;
            5'b100_01, 5'b100_11: m = 16'h0264;
            5'b101_00: m = 16'h0470;  5'b101_01: m = 16'h0322;
            5'b101_10: m = 16'h0071;  5'b101_11: m = 16'h0226;
            5'b110_00: m = 16'h0170;  5'b110_01: m = 16'h0223;
            5'b110_10: m = 16'h0074;  5'b110_11: m = 16'h0622;
            default:   m = 16'h0000;
        endcase
        return m;
    endfunction

    function automatic logic [23:0] palette(input logic [3:0] c);
        logic [23:0] p;
        case (c)
            4'd0: p = 24'h000000;  4'd1: p = 24'h00FFFF;
            4'd2: p = 24'hFFFF00;  4'd3: p = 24'hFF00FF;
            4'd4: p = 24'h00FF00;  4'd5: p = 24'hFF0000;
            4'd6: p = 24'h0000FF;  4'd7: p = 24'hFF8000;
            default: p = 24'h808080;
        endcase
        return p;
    endfunction

    // Piece / clear-row state is only sampled on vs rise so a frame never tears.
    logic            r_vs_d, r_piece_ok;
    logic [7:0]      r_frame;
    logic [2:0]      r_shape;
    logic [1:0]      r_rot;
    logic [4:0]      r_cur_x;
    logic [5:0]      r_cur_y;
    logic [3:0]      r_color;
    logic [ROWS-1:0] r_clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_d <= 1'b0;  r_piece_ok <= 1'b0;  r_frame <= '0;
            r_shape <= '0;   r_rot <= '0;         r_cur_x <= '0;
            r_cur_y <= '0;   r_color <= '0;       r_clear <= '0;
        end else begin
            r_vs_d <= hve[1];
            if (hve[1] && !r_vs_d) begin
                r_shape <= cur_shape;  r_rot <= cur_rot;  r_cur_x <= cur_x;
                r_cur_y <= cur_y;      r_color <= cur_color;
                r_clear <= clear_rows;
                r_piece_ok <= 1'b1;
                r_frame <= r_frame + 8'd1;
            end
        end
    end

    logic [12:0] w_dx, w_dy;
    logic [4:0]  w_bx, w_by;
    logic [6:0]  w_relx, w_rely;
    logic [15:0] w_mask;
    logic [31:0] w_clr32;
    logic        w_inb, w_grid, w_hit, w_phase, w_flash;

    assign w_dx    = x - 13'(X0);
    assign w_dy    = y - 13'(Y0);
    assign w_inb   = ({1'b0, x} >= XS) && ({1'b0, x} < XE) && ({1'b0, y} >= YS) && ({1'b0, y} < YE);
    assign w_bx    = 5'(w_dx >> BLK_LOG2);
    assign w_by    = 5'(w_dy >> BLK_LOG2);
    assign w_grid  = ((w_dx & BMASK) == '0) || ((w_dy & BMASK) == '0);
    assign w_relx  = {2'b00, w_bx} - {2'b00, r_cur_x};
    assign w_rely  = {2'b00, w_by} - {r_cur_y[5], r_cur_y};
    assign w_mask  = shape_mask(r_shape, r_rot);
    assign w_hit   = (w_relx[6:2] == '0) && (w_rely[6:2] == '0) &&
                     w_mask[{w_rely[1:0], w_relx[1:0]}] && r_piece_ok && (r_shape != 3'd7);
    assign w_clr32 = 32'(r_clear);
    assign w_phase = |(r_frame & 8'(FLASH_FRAMES));
    assign w_flash = w_clr32[w_by] && w_phase;

    // Side-band {de, in_board, grid, hit, flash, piece colour} rides alongside the memory read.
    logic [MEM_LAT:0][8:0] r_sb;
    logic [LAT-1:0][2:0]   r_hve;
    logic [4:0]            r_req_bx, r_req_by;
    logic                  r_req_valid;
    logic [23:0]           r_rgb, w_rgb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sb <= '0;  r_hve <= '0;  r_rgb <= '0;
            r_req_bx <= '0;  r_req_by <= '0;  r_req_valid <= 1'b0;
        end else begin
            r_req_bx    <= w_inb ? w_bx : 5'd0;
            r_req_by    <= w_inb ? w_by : 5'd0;
            r_req_valid <= w_inb;
            r_sb        <= {r_sb[MEM_LAT-1:0], {hve[2], w_inb, w_grid, w_hit, w_flash, r_color}};
            r_hve       <= {r_hve[LAT-2:0], hve};
            r_rgb       <= w_rgb;
        end
    end

    always_comb begin
        w_rgb = 24'h0A0A10;
        if (!r_sb[MEM_LAT][8])      w_rgb = 24'h000000;
        else if (!r_sb[MEM_LAT][7]) w_rgb = 24'h101018;
        else if (r_sb[MEM_LAT][5])  w_rgb = palette(r_sb[MEM_LAT][3:0]);
        else if (r_sb[MEM_LAT][4])  w_rgb = 24'hFFFFFF;
        else if (req_color != 4'd0) w_rgb = palette(req_color);
        else if (r_sb[MEM_LAT][6])  w_rgb = 24'h202030;
    end

    assign req_bx    = r_req_bx;
    assign req_by    = r_req_by;
    assign req_valid = r_req_valid;
    assign rgb       = r_rgb;
    assign hve_o     = r_hve[LAT-1];
endmodule

// File: tb/tb_tetris_video_pipe.sv
// Directed bench: default-latency renderer and a MEM_LAT=3 copy fed identical pixels,
// each with its own board memory model; expectations are hand-computed colours.
module tb_tetris_video_pipe;
    logic        clk, reset_n;
    logic [12:0] x, y;
    logic [2:0]  hve;
    logic [2:0]  cur_shape;
    logic [1:0]  cur_rot;
    logic [4:0]  cur_x;
    logic [5:0]  cur_y;
    logic [3:0]  cur_color;
    logic [19:0] clear_rows;
    logic [4:0]  req_bx1, req_by1, req_bx3, req_by3;
    logic        rv1, rv3;
    logic [3:0]  rc1, rc3, m3a, m3b;
    logic [23:0] rgb1, rgb3;
    logic [2:0]  hveo1, hveo3;
    logic [3:0]  board [0:31][0:31];
    int          n_chk, n_fail;

    tetris_video_pipe u_dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .hve(hve),
        .req_bx(req_bx1), .req_by(req_by1), .req_valid(rv1), .req_color(rc1),
        .cur_shape(cur_shape), .cur_rot(cur_rot), .cur_x(cur_x), .cur_y(cur_y),
        .cur_color(cur_color), .clear_rows(clear_rows), .rgb(rgb1), .hve_o(hveo1));

    tetris_video_pipe #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .hve(hve),
        .req_bx(req_bx3), .req_by(req_by3), .req_valid(rv3), .req_color(rc3),
        .cur_shape(cur_shape), .cur_rot(cur_rot), .cur_x(cur_x), .cur_y(cur_y),
        .cur_color(cur_color), .clear_rows(clear_rows), .rgb(rgb3), .hve_o(hveo3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board memories: 1-cycle and 3-cycle registered reads.
    always @(posedge clk) begin
        rc1 <= board[req_by1][req_bx1];
        m3a <= board[req_by3][req_bx3];
        m3b <= m3a;
        rc3 <= m3b;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    // One-cycle pixel, then idle; checks req at edge 1 and rgb/hve_o one edge early and on time.
    task automatic px(input string tag, input int px_x, input int px_y, input logic [2:0] h,
                      input logic [23:0] e_rgb, input logic [4:0] ebx, input logic [4:0] eby,
                      input logic ev);
        @(negedge clk); x = 13'(px_x); y = 13'(px_y); hve = h;
        @(posedge clk); #1;
        chk({tag, ".bx1"}, 32'(req_bx1), 32'(ebx));  chk({tag, ".by1"}, 32'(req_by1), 32'(eby));
        chk({tag, ".v1"},  32'(rv1), 32'(ev));       chk({tag, ".bx3"}, 32'(req_bx3), 32'(ebx));
        chk({tag, ".by3"}, 32'(req_by3), 32'(eby));  chk({tag, ".v3"},  32'(rv3), 32'(ev));
        @(negedge clk); x = '0; y = '0; hve = '0;
        @(posedge clk); #1;
        chk({tag, ".early1"}, 32'(rgb1), 32'h0);  chk({tag, ".hearly1"}, 32'(hveo1), 32'h0);
        @(posedge clk); #1;
        chk({tag, ".rgb1"}, 32'(rgb1), 32'(e_rgb));  chk({tag, ".hve1"}, 32'(hveo1), 32'(h));
        @(posedge clk); #1;
        chk({tag, ".early3"}, 32'(rgb3), 32'h0);  chk({tag, ".hearly3"}, 32'(hveo3), 32'h0);
        @(posedge clk); #1;
        chk({tag, ".rgb3"}, 32'(rgb3), 32'(e_rgb));  chk({tag, ".hve3"}, 32'(hveo3), 32'(h));
    endtask

    task automatic vs_pulse();
        @(negedge clk); hve = 3'b010;
        @(negedge clk); hve = 3'b000;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        reset_n = 1'b0; x = '0; y = '0; hve = '0;
        cur_shape = 3'd7; cur_rot = '0; cur_x = '0; cur_y = '0; cur_color = '0; clear_rows = '0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) board[r][c] = 4'd0;
        board[5][2] = 4'd5; board[5][4] = 4'd5; board[4][3] = 4'd3;

        repeat (3) @(posedge clk); #1;
        chk("rst.rgb1", 32'(rgb1), 0);  chk("rst.hve1", 32'(hveo1), 0);
        chk("rst.req1", 32'({req_bx1, req_by1, rv1}), 0);
        chk("rst.rgb3", 32'(rgb3), 0);  chk("rst.req3", 32'({req_bx3, req_by3, rv3}), 0);
        @(negedge clk); reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic regions and boundaries
        px("left_out",  199, 0,   3'b100, 24'h101018, 0, 0, 0);
        px("corner",    200, 0,   3'b100, 24'h202030, 0, 0, 1);
        px("interior",  210, 10,  3'b101, 24'h0A0A10, 0, 0, 1);
        px("de_off",    210, 10,  3'b001, 24'h000000, 0, 0, 1);
        px("cell25",    274, 170, 3'b100, 24'hFF0000, 2, 5, 1);
        px("last_cell", 519, 639, 3'b100, 24'h0A0A10, 9, 19, 1);
        px("right_out", 520, 639, 3'b100, 24'h101018, 0, 0, 0);
        px("bot_out",   519, 640, 3'b100, 24'h101018, 0, 0, 0);

        // O piece: invisible until the first vs rise
        cur_shape = 3'd1; cur_rot = 2'd0; cur_x = 5'd3; cur_y = 6'd4; cur_color = 4'd2;
        px("o_pre",     333, 165, 3'b100, 24'hFF0000, 4, 5, 1);
        vs_pulse();
        px("o_45",      333, 165, 3'b100, 24'hFFFF00, 4, 5, 1);
        px("o_56",      365, 197, 3'b100, 24'hFFFF00, 5, 6, 1);
        px("o_grid",    328, 165, 3'b100, 24'hFFFF00, 4, 5, 1);
        px("o_34",      301, 133, 3'b100, 24'hFF00FF, 3, 4, 1);
        cur_shape = 3'd7;
        px("o_midfrm",  333, 165, 3'b100, 24'hFFFF00, 4, 5, 1);

        // Vertical I straddling the top edge
        cur_shape = 3'd0; cur_rot = 2'd1; cur_x = 5'd0; cur_y = 6'h3E; cur_color = 4'd1;
        vs_pulse();
        px("i_10",      237, 5,   3'b100, 24'h00FFFF, 1, 0, 1);
        px("i_11",      237, 37,  3'b100, 24'h00FFFF, 1, 1, 1);
        px("i_12",      237, 69,  3'b100, 24'h0A0A10, 1, 2, 1);
        px("i_00",      205, 5,   3'b100, 24'h0A0A10, 0, 0, 1);
        cur_shape = 3'd7;
        vs_pulse();
        px("nopiece",   237, 5,   3'b100, 24'h0A0A10, 1, 0, 1);

        // Row 7 flash over frames 4..16
        cur_shape = 3'd1; cur_rot = 2'd0; cur_x = 5'd3; cur_y = 6'd6; cur_color = 4'd2;
        clear_rows = 20'h00080;
        for (int f = 4; f <= 16; f++) begin
            vs_pulse();
            if (f == 9) clear_rows = '0;
            px("flash_r7", 205, 229, 3'b100, (f >= 8 && f <= 15) ? 24'hFFFFFF : 24'h0A0A10, 0, 7, 1);
            if (f == 9) clear_rows = 20'h00080;
            if (f == 8) begin
                px("flash_grid",  200, 224, 3'b100, 24'hFFFFFF, 0, 7, 1);
                px("flash_piece", 333, 229, 3'b100, 24'hFFFF00, 4, 7, 1);
                px("flash_r6",    205, 197, 3'b100, 24'h0A0A10, 0, 6, 1);
            end
            if (f == 16) px("unflash_grid", 200, 224, 3'b100, 24'h202030, 0, 7, 1);
        end

        // Asynchronous reset in the middle of a line
        @(negedge clk); x = 13'd333; y = 13'd229; hve = 3'b100;
        repeat (6) @(posedge clk); #1;
        chk("pre_rst.rgb1", 32'(rgb1), 32'hFFFF00);  chk("pre_rst.hve1", 32'(hveo1), 32'h4);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst.rgb1", 32'(rgb1), 0);  chk("mid_rst.hve1", 32'(hveo1), 0);
        chk("mid_rst.req1", 32'({req_bx1, req_by1, rv1}), 0);
        chk("mid_rst.rgb3", 32'(rgb3), 0);  chk("mid_rst.hve3", 32'(hveo3), 0);
        @(negedge clk); x = '0; y = '0; hve = '0;
        repeat (2) @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);
        px("post_rst_hidden", 333, 229, 3'b100, 24'h0A0A10, 4, 7, 1);
        vs_pulse();
        px("post_rst_piece",  333, 229, 3'b100, 24'hFFFF00, 4, 7, 1);
        px("post_rst_r7",     205, 229, 3'b100, 24'h0A0A10, 0, 7, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
